// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer, stopwatch and display path:
// field widths, limits, epoch slice offsets, state encoding and value helpers.
package timer_pkg;

  localparam int HOUR_W  = 6;
  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;
  localparam int MS_W    = 10;
  localparam int EPOCH_W = HOUR_W + MIN_W + SEC_W;

  localparam int SEC_LSB  = 0;
  localparam int MIN_LSB  = SEC_LSB + SEC_W;
  localparam int HOUR_LSB = MIN_LSB + MIN_W;

  localparam logic [HOUR_W-1:0] MAX_HOUR = 6'd23;
  localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
  localparam logic [SEC_W-1:0]  MAX_SEC  = 6'd59;
  localparam logic [MS_W-1:0]   MAX_MS   = 10'd999;

  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_PAUSED_ENC  = 2'd1;
  localparam logic [1:0] ST_RUNNING_ENC = 2'd2;
  localparam logic [1:0] ST_EXPIRED_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_PAUSED  = ST_PAUSED_ENC,
    ST_RUNNING = ST_RUNNING_ENC,
    ST_EXPIRED = ST_EXPIRED_ENC
  } timer_state_e;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  minute;
    logic [SEC_W-1:0]  second;
    logic [MS_W-1:0]   ms;
  } timer_val_t;

  // Each field saturates on its own; an out-of-range minute does not touch the hour.
  function automatic timer_val_t clamp_val(input logic [EPOCH_W-1:0] ep,
                                           input logic [MS_W-1:0]    ms);
    timer_val_t v;
    v.hour   = ep[HOUR_LSB +: HOUR_W];
    v.minute = ep[MIN_LSB +: MIN_W];
    v.second = ep[SEC_LSB +: SEC_W];
    v.ms     = ms;
    if (v.hour > MAX_HOUR)  v.hour   = MAX_HOUR;
    if (v.minute > MAX_MIN) v.minute = MAX_MIN;
    if (v.second > MAX_SEC) v.second = MAX_SEC;
    if (v.ms > MAX_MS)      v.ms     = MAX_MS;
    return v;
  endfunction

  // Callers guarantee v is non-zero, so the hour never wraps.
  function automatic timer_val_t dec_val(input timer_val_t v);
    timer_val_t r;
    r = v;
    if (v.ms != '0) begin
      r.ms = v.ms - MS_W'(1);
    end else begin
      r.ms = MAX_MS;
      if (v.second != '0) begin
        r.second = v.second - SEC_W'(1);
      end else begin
        r.second = MAX_SEC;
        if (v.minute != '0) begin
          r.minute = v.minute - MIN_W'(1);
        end else begin
          r.minute = MAX_MIN;
          r.hour   = v.hour - HOUR_W'(1);
        end
      end
    end
    return r;
  endfunction

  function automatic logic is_zero(input timer_val_t v);
    return (v == '0);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Clock-enable generator: counts 0..DIV-1 while enabled and strobes tick on the
// last count. Shared by the countdown timer and the stopwatch.
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: loads a clamped {hour,minute,second}.ms value, counts down once
// per tick while run is high, and flags expiry at zero.
//   state      | meaning
//   ST_IDLE    | out of reset, nothing loaded
//   ST_PAUSED  | value loaded or held, waiting for run
//   ST_RUNNING | decrementing on every divider tick
//   ST_EXPIRED | reached zero, sticky until load
module countdown_timer
  import timer_pkg::*;
#(
  parameter int CLOCK_HZ = 50_000_000,
  parameter int TICK_HZ  = 1_000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic [EPOCH_W-1:0] load_epoch,
  input  logic [MS_W-1:0]    load_m_epoch,
  input  logic               run,
  output logic [EPOCH_W-1:0] epoch,
  output logic [MS_W-1:0]    m_epoch,
  output logic               running,
  output logic               expired,
  output logic               expired_pulse
);

  localparam int DIV = CLOCK_HZ / TICK_HZ;

  timer_state_e state_q, state_d;
  timer_val_t   val_q, val_d;
  timer_val_t   val_dec;
  logic         tick;
  logic         running_q, expired_q, pulse_q;

  // Any exit from RUNNING restarts the millisecond from scratch.
  tick_divider #(.DIV(DIV)) u_tick_divider (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (state_q == ST_RUNNING),
    .clear   (state_d != ST_RUNNING),
    .tick    (tick)
  );

  assign val_dec = dec_val(val_q);

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    if (load) begin
      state_d = ST_PAUSED;
      val_d   = clamp_val(load_epoch, load_m_epoch);
    end else begin
      case (state_q)
        ST_PAUSED: begin
          if (run) state_d = is_zero(val_q) ? ST_EXPIRED : ST_RUNNING;
        end
        ST_RUNNING: begin
          if (!run) begin
            state_d = ST_PAUSED;
          end else if (tick) begin
            val_d = val_dec;
            if (is_zero(val_dec)) state_d = ST_EXPIRED;
          end
        end
        ST_EXPIRED: val_d = '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      val_q     <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      val_q     <= val_d;
      running_q <= (state_d == ST_RUNNING);
      expired_q <= (state_d == ST_EXPIRED);
      pulse_q   <= (state_d == ST_EXPIRED) && (state_q != ST_EXPIRED);
    end
  end

  assign epoch         = {val_q.hour, val_q.minute, val_q.second};
  assign m_epoch       = val_q.ms;
  assign running       = running_q;
  assign expired       = expired_q;
  assign expired_pulse = pulse_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: a total-milliseconds reference model feeds a per-cycle
// scoreboard, with directed checks at the interesting points.
module tb_countdown_timer;

  localparam int CLOCK_HZ = 4000;
  localparam int TICK_HZ  = 1000;
  localparam int DIV      = CLOCK_HZ / TICK_HZ;

  localparam int M_IDLE  = 0;
  localparam int M_PAUSE = 1;
  localparam int M_RUN   = 2;
  localparam int M_EXP   = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic        run = 1'b0;
  logic [17:0] load_epoch = '0;
  logic [9:0]  load_m_epoch = '0;
  logic [17:0] epoch;
  logic [9:0]  m_epoch;
  logic        running, expired, expired_pulse;

  int vec_cnt = 0;
  int err_cnt = 0;

  countdown_timer #(.CLOCK_HZ(CLOCK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .load          (load),
    .load_epoch    (load_epoch),
    .load_m_epoch  (load_m_epoch),
    .run           (run),
    .epoch         (epoch),
    .m_epoch       (m_epoch),
    .running       (running),
    .expired       (expired),
    .expired_pulse (expired_pulse)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    vec_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [17:0] epoch_of(input int ms);
    int h, m, s;
    h = ms / 3600000;
    m = (ms / 60000) % 60;
    s = (ms / 1000) % 60;
    return {6'(h), 6'(m), 6'(s)};
  endfunction

  function automatic int clamp_ms(input logic [17:0] e, input logic [9:0] ms);
    int h, m, s, x;
    h = int'(e[17:12]); m = int'(e[11:6]); s = int'(e[5:0]); x = int'(ms);
    if (h > 23) h = 23;
    if (m > 59) m = 59;
    if (s > 59) s = 59;
    if (x > 999) x = 999;
    return h * 3600000 + m * 60000 + s * 1000 + x;
  endfunction

  typedef struct {
    logic [17:0] ep;
    logic [9:0]  ms;
    logic        run_o;
    logic        exp_o;
    logic        pls_o;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;

  int m_st = M_IDLE;
  int m_ms = 0;
  int m_div = 0;
  int m_prev = M_IDLE;
  bit m_tick = 1'b0;
  bit m_pls = 1'b0;

  // Reference model: time kept as total milliseconds, so borrows fall out of arithmetic.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_st = M_IDLE; m_ms = 0; m_div = 0; m_pls = 1'b0;
    end else begin
      m_prev = m_st;
      m_tick = (m_st == M_RUN) && (m_div == DIV - 1);
      if (load) begin
        m_ms = clamp_ms(load_epoch, load_m_epoch);
        m_st = M_PAUSE;
      end else begin
        case (m_st)
          M_PAUSE: if (run) m_st = (m_ms == 0) ? M_EXP : M_RUN;
          M_RUN: begin
            if (!run) m_st = M_PAUSE;
            else if (m_tick) begin
              m_ms = m_ms - 1;
              if (m_ms == 0) m_st = M_EXP;
            end
          end
          default: ;
        endcase
      end
      m_div = (m_prev == M_RUN && m_st == M_RUN) ? (m_div + 1) % DIV : 0;
      m_pls = (m_st == M_EXP) && (m_prev != M_EXP);
    end
    if (clock)
      sb_q.push_back('{epoch_of(m_ms), 10'(m_ms % 1000), m_st == M_RUN, m_st == M_EXP, m_pls});
  end

  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      sb_e = sb_q.pop_front();
      check_val("sb_epoch",   epoch,         sb_e.ep);
      check_val("sb_m_epoch", m_epoch,       sb_e.ms);
      check_val("sb_running", running,       sb_e.run_o);
      check_val("sb_expired", expired,       sb_e.exp_o);
      check_val("sb_pulse",   expired_pulse, sb_e.pls_o);
    end
  end

  int run_cyc = 0;
  int pls_cnt = 0;
  always @(negedge clock) begin
    if (running) run_cyc++;
    if (expired_pulse) pls_cnt++;
  end

  task automatic do_load(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s,
                         input logic [9:0] ms);
    @(negedge clock);
    load_epoch = {h, m, s};
    load_m_epoch = ms;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic wait_expired(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (expired === 1'b1) break;
      @(negedge clock);
    end
    check_val("expired_within_budget", expired, 1'b1);
  endtask

  int run0, pls0;

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    check_val("rst_epoch", epoch, 18'd0);
    check_val("rst_m_epoch", m_epoch, 10'd0);
    check_val("rst_running", running, 1'b0);
    check_val("rst_expired", expired, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check_val("idle_run_ignored", running, 1'b0);

    // 1: 0:00:01.002 counts fully down
    do_load(6'd0, 6'd0, 6'd1, 10'd2);
    check_val("t1_load_epoch", epoch, {6'd0, 6'd0, 6'd1});
    check_val("t1_load_ms", m_epoch, 10'd2);
    run0 = run_cyc; pls0 = pls_cnt;
    run = 1'b1;
    wait_expired(5000);
    check_val("t1_run_cycles", run_cyc - run0, 1002 * DIV);
    check_val("t1_zero_epoch", epoch, 18'd0);
    check_val("t1_zero_ms", m_epoch, 10'd0);
    check_val("t1_running", running, 1'b0);
    repeat (5) @(negedge clock);
    check_val("t1_pulse_count", pls_cnt - pls0, 1);
    check_val("t1_sticky", expired, 1'b1);
    run = 1'b0;

    // 2: triple borrow on the first tick
    do_load(6'd1, 6'd0, 6'd0, 10'd0);
    run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (m_epoch !== 10'd0) break;
      @(negedge clock);
    end
    check_val("t2_borrow_epoch", epoch, {6'd0, 6'd59, 6'd59});
    check_val("t2_borrow_ms", m_epoch, 10'd999);
    run = 1'b0;

    // 3: clamping, all fields and a mixed case
    do_load(6'd40, 6'd60, 6'd63, 10'd1023);
    check_val("t3_clamp_epoch", epoch, {6'd23, 6'd59, 6'd59});
    check_val("t3_clamp_ms", m_epoch, 10'd999);
    check_val("t3_paused", running, 1'b0);
    do_load(6'd24, 6'd5, 6'd60, 10'd500);
    check_val("t3_mixed_epoch", epoch, {6'd23, 6'd5, 6'd59});
    check_val("t3_mixed_ms", m_epoch, 10'd500);

    // 4: pause freezes the value, restart gives a full ms before the next tick
    do_load(6'd0, 6'd0, 6'd5, 10'd0);
    run = 1'b1;
    repeat (30) @(negedge clock);
    run = 1'b0;
    repeat (10) @(negedge clock);
    check_val("t4_frozen_epoch", epoch, {6'd0, 6'd0, 6'd4});
    check_val("t4_frozen_ms", m_epoch, 10'd993);
    run = 1'b1;
    repeat (4) @(negedge clock);
    check_val("t4_before_tick", m_epoch, 10'd993);
    @(negedge clock);
    check_val("t4_after_tick", m_epoch, 10'd992);

    // 5: load coinciding with a tick
    for (int i = 0; i < 20; i++) begin
      if (m_st == M_RUN && m_div == DIV - 1) break;
      @(negedge clock);
    end
    check_val("t5_aligned_running", running, 1'b1);
    load_epoch = {6'd0, 6'd2, 6'd0};
    load_m_epoch = 10'd7;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    check_val("t5_load_epoch", epoch, {6'd0, 6'd2, 6'd0});
    check_val("t5_load_ms", m_epoch, 10'd7);
    check_val("t5_paused", running, 1'b0);

    // 6: async reset mid-count, then immediate expiry from a zero load
    repeat (12) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check_val("t6_rst_epoch", epoch, 18'd0);
    check_val("t6_rst_ms", m_epoch, 10'd0);
    check_val("t6_rst_running", running, 1'b0);
    check_val("t6_rst_pulse", expired_pulse, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    run = 1'b1;
    pls0 = pls_cnt;
    do_load(6'd0, 6'd0, 6'd0, 10'd0);
    check_val("t6_paused_first", expired, 1'b0);
    @(negedge clock);
    check_val("t6_expired", expired, 1'b1);
    check_val("t6_pulse", expired_pulse, 1'b1);
    repeat (4) @(negedge clock);
    check_val("t6_pulse_count", pls_cnt - pls0, 1);
    run = 1'b0;

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d miscompares %0d",
             vec_cnt, err_cnt);
    $fatal(1, "watchdog");
  end

endmodule
